// File: rtl/sc_stream_counter.sv
// -----------------------------------------------------------------------------
// sc_stream_counter
//
// Converts a stochastic bit stream back into a binary value. After a start
// request in IDLE, the block counts the ones among the next 2^CNT_W qualified
// bits. It then holds the count on `result` with `result_valid` high until the
// count is acknowledged.
//
// Parameters
//   CNT_W        : log2 of the stream length (default 8 -> 256 bits).
//
// Ports
//   clk          : in  single clock, rising-edge active
//   rst_n        : in  asynchronous active-low reset
//   start        : in  request a new conversion (honoured in IDLE only)
//   bit_in       : in  stochastic bit from the upstream circuit
//   bit_valid    : in  qualifies bit_in in the current cycle
//   result_ack   : in  releases a held result (DONE -> IDLE)
//   busy         : out high while a stream is being counted (RUN)
//   result       : out number of ones in the last finished stream, 0..2^CNT_W
//   result_valid : out high while a finished result is held (DONE)
//   bits_seen    : out running valid-bit index in RUN, 0 otherwise
// -----------------------------------------------------------------------------
module sc_stream_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic [CNT_W:0]   result,
  output logic             result_valid,
  output logic [CNT_W-1:0] bits_seen
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W:0]   ones_q,       ones_d;
  logic [CNT_W-1:0] len_q,        len_d;
  logic [CNT_W:0]   result_q,     result_d;
  logic             busy_q,       busy_d;
  logic             valid_q,      valid_d;
  logic [CNT_W-1:0] bits_seen_q,  bits_seen_d;

  // The ones count plus the bit being accepted now. The count holds at most
  // 2^CNT_W, so the CNT_W+1 bits of the sum never wrap.
  logic [CNT_W:0] ones_plus_bit;
  assign ones_plus_bit = ones_q + {{CNT_W{1'b0}}, bit_in};

  always_comb begin
    // NOTE: every variable is given its hold value first. No path through the
    // case statement can leave one unassigned, so no latch is inferred.
    state_d  = state_q;
    ones_d   = ones_q;
    len_d    = len_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ones_d  = '0;
          len_d   = '0;
        end
      end

      ST_RUN: begin
        if (bit_valid) begin
          ones_d = ones_plus_bit;
          len_d  = len_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // The bit accepted at index 2^CNT_W-1 ends the stream. It must be
          // included in the result, so the sum is loaded directly.
          if (len_q == {CNT_W{1'b1}}) begin
            state_d  = ST_DONE;
            result_d = ones_plus_bit;
          end
        end
      end

      ST_DONE: begin
        // A start request in this same cycle is dropped on purpose. A new
        // conversion can only begin from IDLE.
        if (result_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The outputs are decoded from the next state, so they come straight out
    // of flops and change exactly with the state register.
    busy_d      = (state_d == ST_RUN);
    valid_d     = (state_d == ST_DONE);
    bits_seen_d = (state_d == ST_RUN) ? len_d : '0;
  end

  // NOTE: all state registers update with non-blocking assignments. Every
  // register then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ones_q      <= '0;
      len_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      bits_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      len_q       <= len_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      bits_seen_q <= bits_seen_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign bits_seen    = bits_seen_q;

endmodule
